// File: rtl/ktt_score_pkg.sv
// Shared types and Q1.7 constants for the score accumulator.
package ktt_score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_e;

    localparam int         Q_FRAC_BITS = 7;
    localparam logic [7:0] Q_ONE       = 8'd128;
    localparam logic [7:0] Q_HALF      = 8'd64;

endpackage

// File: rtl/score_accumulator_if.sv
// Hit handshake between the decay-multiplier stage (master) and the score accumulator (slave).
interface score_accumulator_if #(
    parameter int POINTS_W = 8
);
    logic                hit_valid;
    logic                hit_ready;
    logic [POINTS_W-1:0] hit_points;
    logic [7:0]          multiple;

    modport master (output hit_valid, output hit_points, output multiple, input hit_ready);
    modport slave  (input hit_valid, input hit_points, input multiple, output hit_ready);
endinterface

// File: rtl/score_accumulator_sat_add.sv
// Unsigned saturating adder: clips to all-ones and flags when the true sum does not fit.
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[W];
    assign sum  = ovf ? '1 : full[W-1:0];
endmodule

// File: rtl/score_accumulator.sv
// Scales each accepted hit by the Q1.7 multiple and adds it into a saturating score.
// Build option: define SCORE_ROUND_EN for round-half-up scaling; otherwise the product is truncated.
module score_accumulator
    import ktt_score_pkg::*;
#(
    parameter int POINTS_W = 8,
    parameter int SCORE_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    score_accumulator_if.slave  hit,
    output logic [SCORE_W-1:0]  score,
    output logic                score_upd,
    output logic                saturated
);

`ifdef SCORE_ROUND_EN
    localparam logic [POINTS_W+7:0] RND = (POINTS_W+8)'(Q_HALF);
`else
    localparam logic [POINTS_W+7:0] RND = '0;
`endif

    state_e              state_q, state_d;
    logic [POINTS_W-1:0] pts_q, pts_d;
    logic [7:0]          mul_q, mul_d;
    logic [POINTS_W:0]   scaled_q, scaled_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                upd_q, upd_d;
    logic                sat_q, sat_d;

    logic [POINTS_W+7:0] prod;
    logic [SCORE_W-1:0]  sum;
    logic                sum_ovf;

    assign prod = (POINTS_W+8)'(pts_q) * (POINTS_W+8)'(mul_q);

    sat_add #(.W(SCORE_W)) u_sat_add (
        .a   (score_q),
        .b   (SCORE_W'(scaled_q)),
        .sum (sum),
        .ovf (sum_ovf)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pts_d         = pts_q;
        mul_d         = mul_q;
        scaled_d      = scaled_q;
        score_d       = score_q;
        sat_d         = sat_q;
        upd_d         = 1'b0;
        hit.hit_ready = 1'b0;

        if (clear) begin
            state_d = IDLE;
            score_d = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    hit.hit_ready = 1'b1;
                    if (hit.hit_valid) begin
                        pts_d   = hit.hit_points;
                        mul_d   = hit.multiple;
                        state_d = MUL;
                    end
                end
                MUL: begin
                    scaled_d = (POINTS_W+1)'((prod + RND) >> Q_FRAC_BITS);
                    state_d  = ACC;
                end
                ACC: begin
                    score_d = sum;
                    if (sum_ovf) sat_d = 1'b1;
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pts_q    <= '0;
            mul_q    <= '0;
            scaled_q <= '0;
            score_q  <= '0;
            upd_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pts_q    <= pts_d;
            mul_q    <= mul_d;
            scaled_q <= scaled_d;
            score_q  <= score_d;
            upd_q    <= upd_d;
            sat_q    <= sat_d;
        end
    end

    assign score     = score_q;
    assign score_upd = upd_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed self-checking bench for score_accumulator (10-bit score so saturation is reachable).
module tb_score_accumulator;

`ifdef SCORE_ROUND_EN
    localparam int RND_BIT = 1;
`else
    localparam int RND_BIT = 0;
`endif

    logic       clk;
    logic       rst;
    logic       clear;
    logic [9:0] score;
    logic       score_upd;
    logic       saturated;

    int         checks;
    int         errors;
    logic [9:0] prev_score;

    score_accumulator_if #(.POINTS_W(8)) hif ();

    score_accumulator #(
        .POINTS_W (8),
        .SCORE_W  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hit       (hif),
        .score     (score),
        .score_upd (score_upd),
        .saturated (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_hit(input string name, input logic [7:0] pts, input logic [7:0] mul,
                           input logic [9:0] exp_score, input logic exp_sat);
        int n;
        n = 0;
        @(negedge clk);
        hif.hit_valid  = 1'b1;
        hif.hit_points = pts;
        hif.multiple   = mul;
        while (hif.hit_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL %s ready_timeout: hit_ready=%b required 1", name, hif.hit_ready);
            hif.hit_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 hif.hit_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hif.hit_ready !== 1'b0 || score_upd !== 1'b0) begin
            errors++;
            $display("FAIL %s mul_phase: ready=%b upd=%b required 0 0", name, hif.hit_ready, score_upd);
        end
        @(negedge clk);
        checks++;
        if (hif.hit_ready !== 1'b0 || score !== prev_score) begin
            errors++;
            $display("FAIL %s acc_phase: ready=%b score=%0d required 0 %0d", name, hif.hit_ready, score, prev_score);
        end
        @(negedge clk);
        checks++;
        if (score !== exp_score) begin
            errors++;
            $display("FAIL %s score: got %0d required %0d", name, score, exp_score);
        end
        checks++;
        if (saturated !== exp_sat) begin
            errors++;
            $display("FAIL %s saturated: got %b required %b", name, saturated, exp_sat);
        end
        checks++;
        if (score_upd !== 1'b1 || hif.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s upd_pulse: upd=%b ready=%b required 1 1", name, score_upd, hif.hit_ready);
        end
        @(negedge clk);
        checks++;
        if (score_upd !== 1'b0) begin
            errors++;
            $display("FAIL %s upd_single: upd=%b required 0", name, score_upd);
        end
        prev_score = exp_score;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear = 1'b0;
        hif.hit_valid = 1'b0;
        hif.hit_points = '0;
        hif.multiple = '0;
        #1;
        checks++;
        if (score !== 10'd0 || saturated !== 1'b0 || score_upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: score=%0d sat=%b upd=%b required 0 0 0", score, saturated, score_upd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (hif.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: hit_ready=%b required 1", hif.hit_ready);
        end
        prev_score = '0;
    endtask

    task automatic test_scaling();
        run_hit("unit_scale", 8'd100, 8'd128, 10'd100, 1'b0);
        run_hit("half_scale", 8'd100, 8'd64, 10'd150, 1'b0);
        run_hit("round_boundary", 8'd3, 8'd34, 10'(150 + RND_BIT), 1'b0);
        run_hit("full_points", 8'd255, 8'd128, 10'(405 + RND_BIT), 1'b0);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (score !== 10'd0 || saturated !== 1'b0 || score_upd !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: score=%0d sat=%b upd=%b required 0 0 0", score, saturated, score_upd);
        end
        prev_score = '0;
        run_hit("sat_hit1", 8'd255, 8'd128, 10'd255, 1'b0);
        run_hit("sat_hit2", 8'd255, 8'd128, 10'd510, 1'b0);
        run_hit("sat_hit3", 8'd255, 8'd128, 10'd765, 1'b0);
        run_hit("sat_hit4", 8'd255, 8'd128, 10'd1020, 1'b0);
        run_hit("sat_hit5", 8'd255, 8'd128, 10'd1023, 1'b1);
        run_hit("sat_hit6", 8'd255, 8'd128, 10'd1023, 1'b1);
    endtask

    task automatic test_rst_in_acc();
        @(negedge clk);
        hif.hit_valid  = 1'b1;
        hif.hit_points = 8'd10;
        hif.multiple   = 8'd128;
        @(posedge clk);
        #1 hif.hit_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (score !== 10'd0 || saturated !== 1'b0 || score_upd !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: score=%0d sat=%b upd=%b required 0 0 0", score, saturated, score_upd);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (hif.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: hit_ready=%b required 1", hif.hit_ready);
        end
        @(negedge clk);
        checks++;
        if (score !== 10'd0 || score_upd !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: score=%0d upd=%b required 0 0", score, score_upd);
        end
        prev_score = '0;
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        hif.hit_points = 8'd1;
        hif.multiple   = 8'd128;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            hif.hit_valid = 1'b1;
            checks++;
            if (hif.hit_ready !== ((i % 3) == 0)) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d: hit_ready=%b required %b", i, hif.hit_ready, (i % 3) == 0);
            end
            if (hif.hit_ready === 1'b1) accepts++;
        end
        @(negedge clk);
        hif.hit_valid = 1'b0;
        checks++;
        if (accepts != 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 4", accepts);
        end
        checks++;
        if (score !== 10'd4) begin
            errors++;
            $display("FAIL b2b_score: got %0d required 4", score);
        end
        prev_score = 10'd4;
    endtask

    task automatic test_clear_with_valid();
        @(negedge clk);
        clear          = 1'b1;
        hif.hit_valid  = 1'b1;
        hif.hit_points = 8'd50;
        hif.multiple   = 8'd128;
        #1;
        checks++;
        if (hif.hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: hit_ready=%b required 0", hif.hit_ready);
        end
        @(negedge clk);
        clear         = 1'b0;
        hif.hit_valid = 1'b0;
        #1;
        checks++;
        if (score !== 10'd0 || hif.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_no_accept: score=%0d ready=%b required 0 1", score, hif.hit_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (score !== 10'd0 || score_upd !== 1'b0) begin
            errors++;
            $display("FAIL clear_later: score=%0d upd=%b required 0 0", score, score_upd);
        end
        prev_score = '0;
    endtask

    task automatic test_abort_clear();
        int upd_seen;
        upd_seen = 0;
        @(negedge clk);
        hif.hit_valid  = 1'b1;
        hif.hit_points = 8'd50;
        hif.multiple   = 8'd128;
        @(posedge clk);
        #1 hif.hit_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        checks++;
        if (hif.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: hit_ready=%b required 1", hif.hit_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (score_upd === 1'b1) upd_seen++;
        end
        checks++;
        if (score !== 10'd0 || upd_seen != 0) begin
            errors++;
            $display("FAIL abort_discard: score=%0d upd_pulses=%0d required 0 0", score, upd_seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_scaling();
        test_saturation();
        test_rst_in_acc();
        test_back_to_back();
        test_clear_with_valid();
        test_abort_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_accumulator.md
# score_accumulator

Converts each scored hit into points and adds them to the running game score. It sits directly downstream of the decay-multiplier stage. On every accepted hit it samples the stage's 8-bit Q1.7 `multiple`, scales the hit's base points by it, and adds the result into a saturating score register. The score register drives the display and readout logic.

## Interface
- `POINTS_W`, default 8: width of base hit points.
- `SCORE_W`, default 16: width of the accumulated score; must be ≥ `POINTS_W`+1.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `clear`  in  1  synchronous score clear; highest priority after reset.
- `hit_valid`  in  1  hit request, held until accepted.
- `hit_ready`  out  1  block can accept a hit this cycle.
- `hit_points`  in  `POINTS_W`  base points for the hit; sampled on accept.
- `multiple`  in  8  Q1.7 scale from the multiplier stage (128 = 1.0); sampled on accept.
- `score`  out  `SCORE_W`  accumulated score.
- `score_upd`  out  1  one-cycle pulse when `score` has just changed due to a hit.
- `saturated`  out  1  sticky; score has clipped at max.

## Operation
- FSM states: IDLE, MUL, ACC.
- IDLE:
  - `hit_ready` = 1 in IDLE only, and only when `clear` = 0.
  - A hit is accepted when `hit_valid` && `hit_ready`: latch `hit_points` and `multiple`, go to MUL.
- MUL:
  - `prod` = `pts` × `mul`, width `POINTS_W`+8.
  - `scaled` = (`prod` + rnd) >> 7, registered.
  - Go to ACC.
- ACC:
  - `score` ← min(`score` + `scaled`, 2^`SCORE_W`−1), zero-extending `scaled`.
  - If the sum clipped, set `saturated`.
  - Pulse `score_upd` in the following cycle.
  - Return to IDLE.
- Multiples above 128 are used as given; there is no clamping.
- `clear`:
  - Sets `score` = 0 and `saturated` = 0.
  - Aborts any in-flight hit (its points are discarded) and forces IDLE.
  - Suppresses `hit_ready` in the same cycle.
  - No `score_upd` pulse is produced by a clear.
- When `clear` and `hit_valid` arrive in the same cycle, the hit is not accepted.
- Reset values: `score` = 0, `saturated` = 0, `score_upd` = 0, state = IDLE, so `hit_ready` = 1 once `rst` = 1.
- Assertion of `rst` mid-operation immediately returns everything to reset values.
- Once saturated, further hits leave `score` at max and still pulse `score_upd`.

## Timing
- Throughput: one hit per 3 cycles.
- Accept at rising edge E0. State is MUL during cycle E0→E1, ACC during E1→E2.
- `score` holds the new value after edge E2; `score_upd` is high for cycle E2→E3.
- `hit_ready` is low from E0 through E2 and high again after E2. A new accept is therefore possible at E3.
- All outputs are registered; there is no combinational path from inputs to outputs except `clear` → `hit_ready`.

## Configuration
- `SCORE_ROUND_EN` defined: rnd = 64, i.e. round-half-up of the Q1.7 product.
- `SCORE_ROUND_EN` undefined: rnd = 0, i.e. truncation.
- No other behaviour differs between the two builds.

## Structure
- Shared package `ktt_score_pkg` holds:
  - the state enum (IDLE/MUL/ACC);
  - `Q_FRAC_BITS` = 7;
  - `Q_ONE` = 8'd128;
  - `Q_HALF` = 8'd64.
- One sub-module, `sat_add`: parameterised-width unsigned saturating adder with an overflow flag, used in ACC.

## Test plan
- Unit scale, rounding build: `hit_points`=100, `multiple`=128 → after 3 edges `score`=100, single `score_upd` pulse, `saturated`=0.
- Half scale, rounding build: `hit_points`=100, `multiple`=64, starting from score 100 → `score`=150.
- Rounding boundary: `hit_points`=3, `multiple`=34 (prod 102) → +1 with `SCORE_ROUND_EN`, +0 without. Also `hit_points`=255, `multiple`=128 → +255 in both builds.
- Saturation: `SCORE_W`=10, five hits of 255 at `multiple`=128 → 255, 510, 765, 1020, then 1023 with `saturated`=1. A sixth hit keeps 1023 and still pulses `score_upd`.
- Handshake:
  - `hit_valid` held high continuously → accepts exactly every 3rd cycle, and `hit_ready` is never high in MUL or ACC.
  - `clear` together with `hit_valid` → no accept, `score`=0.
- Abort:
  - `clear` asserted in MUL → that hit's points are never added and state is IDLE next cycle.
  - `rst` pulsed low in ACC → `score`=0 and `saturated`=0 immediately (asynchronously), with no `score_upd` pulse.
